// File: rtl/cond_exec_stage_if.sv
// ---------------------------------------------------------------------------
// cond_exec_stage_if
// Bundles the decode/execute pipeline-register outputs, the memory-stage
// stall/flush controls and the execute/memory pipeline-register outputs of
// cond_exec_stage.
//   master : drives the E-side controls/data plus StallM/FlushM and observes
//            the results.
//   slave  : the execute stage itself (cond_exec_stage).
// Parameters: WIDTH = datapath width, RW = register-address width.
// ---------------------------------------------------------------------------
interface cond_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int RW    = 4
);
  // Execute-side inputs
  logic             PCSrcE;
  logic             RegWriteE;
  logic             MemtoRegE;
  logic             MemWriteE;
  logic [1:0]       FlagWriteE;
  logic [3:0]       CondE;
  logic [3:0]       ALUFlags;
  logic [WIDTH-1:0] ALUResultE;
  logic [WIDTH-1:0] WriteDataE;
  logic [RW-1:0]    WA3E;
  logic             StallM;
  logic             FlushM;
  // Results
  logic             CondExE;
  logic             BranchTakenE;
  logic [3:0]       Flags;
  logic             PCSrcM;
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             MemWriteM;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] WriteDataM;
  logic [RW-1:0]    WA3M;

  modport master (
    output PCSrcE, RegWriteE, MemtoRegE, MemWriteE, FlagWriteE, CondE,
           ALUFlags, ALUResultE, WriteDataE, WA3E, StallM, FlushM,
    input  CondExE, BranchTakenE, Flags, PCSrcM, RegWriteM, MemtoRegM,
           MemWriteM, ALUResultM, WriteDataM, WA3M
  );

  modport slave (
    input  PCSrcE, RegWriteE, MemtoRegE, MemWriteE, FlagWriteE, CondE,
           ALUFlags, ALUResultE, WriteDataE, WA3E, StallM, FlushM,
    output CondExE, BranchTakenE, Flags, PCSrcM, RegWriteM, MemtoRegM,
           MemWriteM, ALUResultM, WriteDataM, WA3M
  );
endinterface

// File: rtl/cond_exec_stage.sv
// ---------------------------------------------------------------------------
// cond_exec_stage
// Execute-stage condition evaluation for an ARM-style pipeline. CondE is
// checked against the architectural NZCV register; a failed condition
// suppresses PCSrc/RegWrite/MemWrite and any flag write. The gated controls
// and datapath values are captured in the execute/memory register, which
// supports flush (bubble) and stall (hold).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : cond_exec_stage_if.slave (E inputs, StallM/FlushM, CondExE,
//           BranchTakenE, Flags and all *M outputs)
// ---------------------------------------------------------------------------
module cond_exec_stage #(
  parameter int WIDTH = 32,
  parameter int RW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  cond_exec_stage_if.slave   bus
);

  // ARM condition table evaluated on {N,Z,C,V}; code F is treated as always.
  function automatic logic cond_pass(input logic [3:0] cond,
                                     input logic [3:0] nzcv);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'hA:    r = ~(n ^ v);
      4'hB:    r = n ^ v;
      4'hC:    r = ~z & ~(n ^ v);
      4'hD:    r = z | (n ^ v);
      4'hE:    r = 1'b1;
      4'hF:    r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [3:0]       flags_q, flags_d;
  logic             pc_src_q, pc_src_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             mem_write_q, mem_write_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [RW-1:0]    wa3_q, wa3_d;
  logic             cond_ex_s;

  // Condition check uses the committed flags, never this cycle's ALUFlags.
  always_comb begin
    cond_ex_s = cond_pass(bus.CondE, flags_q);
  end

  // Flag update: only on an unstalled, condition-passing instruction.
  always_comb begin
    flags_d = flags_q;
    if (!bus.StallM && cond_ex_s) begin
      if (bus.FlagWriteE[1]) begin
        flags_d[3:2] = bus.ALUFlags[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (bus.FlagWriteE[0]) begin
        flags_d[1:0] = bus.ALUFlags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Execute/memory register next state: flush beats stall beats load.
  always_comb begin
    pc_src_d     = pc_src_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    wa3_d        = wa3_q;
    if (bus.FlushM) begin
      pc_src_d     = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_result_d = {WIDTH{1'b0}};
      write_data_d = {WIDTH{1'b0}};
      wa3_d        = {RW{1'b0}};
    end else if (bus.StallM) begin
      pc_src_d     = pc_src_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      mem_write_d  = mem_write_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      wa3_d        = wa3_q;
    end else begin
      pc_src_d     = bus.PCSrcE & cond_ex_s;
      reg_write_d  = bus.RegWriteE & cond_ex_s;
      mem_to_reg_d = bus.MemtoRegE;
      mem_write_d  = bus.MemWriteE & cond_ex_s;
      alu_result_d = bus.ALUResultE;
      write_data_d = bus.WriteDataE;
      wa3_d        = bus.WA3E;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q      <= 4'b0000;
      pc_src_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_result_q <= {WIDTH{1'b0}};
      write_data_q <= {WIDTH{1'b0}};
      wa3_q        <= {RW{1'b0}};
    end else begin
      flags_q      <= flags_d;
      pc_src_q     <= pc_src_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      wa3_q        <= wa3_d;
    end
  end

  assign bus.CondExE      = cond_ex_s;
  assign bus.BranchTakenE = bus.PCSrcE & cond_ex_s;
  assign bus.Flags        = flags_q;
  assign bus.PCSrcM       = pc_src_q;
  assign bus.RegWriteM    = reg_write_q;
  assign bus.MemtoRegM    = mem_to_reg_q;
  assign bus.MemWriteM    = mem_write_q;
  assign bus.ALUResultM   = alu_result_q;
  assign bus.WriteDataM   = write_data_q;
  assign bus.WA3M         = wa3_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_stage
// Self-checking bench for cond_exec_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_cond_exec_stage;
  localparam int WIDTH = 32;
  localparam int RW    = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  cond_exec_stage_if #(.WIDTH(WIDTH), .RW(RW)) bus ();

  cond_exec_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]       m_flags;
  logic             m_pc, m_rw, m_mtr, m_mw;
  logic [WIDTH-1:0] m_alu, m_wd;
  logic [RW-1:0]    m_wa3;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert the even one.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cc == 4'hF) return 1'b1;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000;
    m_pc = 1'b0; m_rw = 1'b0; m_mtr = 1'b0; m_mw = 1'b0;
    m_alu = '0; m_wd = '0; m_wa3 = '0;
  endtask

  task automatic set_idle();
    bus.PCSrcE = 1'b0; bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0;
    bus.MemWriteE = 1'b0; bus.FlagWriteE = 2'b00; bus.CondE = 4'hE;
    bus.ALUFlags = 4'h0; bus.ALUResultE = '0; bus.WriteDataE = '0;
    bus.WA3E = '0; bus.StallM = 1'b0; bus.FlushM = 1'b0;
  endtask

  task automatic drive_random();
    bus.PCSrcE     = 1'($urandom_range(1, 0));
    bus.RegWriteE  = 1'($urandom_range(1, 0));
    bus.MemtoRegE  = 1'($urandom_range(1, 0));
    bus.MemWriteE  = 1'($urandom_range(1, 0));
    bus.FlagWriteE = 2'($urandom_range(3, 0));
    bus.CondE      = 4'($urandom_range(15, 0));
    bus.ALUFlags   = 4'($urandom_range(15, 0));
    bus.ALUResultE = $urandom;
    bus.WriteDataE = $urandom;
    bus.WA3E       = 4'($urandom_range(15, 0));
    bus.StallM     = ($urandom_range(4, 0) == 0);
    bus.FlushM     = ($urandom_range(5, 0) == 0);
  endtask

  task automatic check_comb();
    logic ce;
    #1;
    ce = ref_cond(bus.CondE, m_flags);
    check_eq("CondExE", 64'(bus.CondExE), 64'(ce));
    check_eq("BranchTakenE", 64'(bus.BranchTakenE), 64'(bus.PCSrcE & ce));
  endtask

  task automatic check_regs();
    check_eq("Flags",      64'(bus.Flags),      64'(m_flags));
    check_eq("PCSrcM",     64'(bus.PCSrcM),     64'(m_pc));
    check_eq("RegWriteM",  64'(bus.RegWriteM),  64'(m_rw));
    check_eq("MemtoRegM",  64'(bus.MemtoRegM),  64'(m_mtr));
    check_eq("MemWriteM",  64'(bus.MemWriteM),  64'(m_mw));
    check_eq("ALUResultM", 64'(bus.ALUResultM), 64'(m_alu));
    check_eq("WriteDataM", 64'(bus.WriteDataM), 64'(m_wd));
    check_eq("WA3M",       64'(bus.WA3M),       64'(m_wa3));
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT,
  // then compare all registered outputs.
  task automatic step();
    logic ce;
    ce = ref_cond(bus.CondE, m_flags);
    if (!bus.StallM && ce) begin
      if (bus.FlagWriteE[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) m_flags[1:0] = bus.ALUFlags[1:0];
    end
    if (bus.FlushM) begin
      m_pc = 1'b0; m_rw = 1'b0; m_mtr = 1'b0; m_mw = 1'b0;
      m_alu = '0; m_wd = '0; m_wa3 = '0;
    end else if (!bus.StallM) begin
      m_pc  = bus.PCSrcE && ce;
      m_rw  = bus.RegWriteE && ce;
      m_mtr = bus.MemtoRegE;
      m_mw  = bus.MemWriteE && ce;
      m_alu = bus.ALUResultE;
      m_wd  = bus.WriteDataE;
      m_wa3 = bus.WA3E;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic set_flags(input logic [3:0] f);
    set_idle();
    bus.FlagWriteE = 2'b11;
    bus.ALUFlags   = f;
    step();
  endtask

  logic [3:0]       hold_flags;
  logic [WIDTH-1:0] hold_alu;

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    reset = 1'b0;
    drive_random();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check_eq("rst_Flags", 64'(bus.Flags), 64'h0);

    // Release reset, then a simple AL register write.
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    bus.RegWriteE  = 1'b1;
    bus.WA3E       = 4'd5;
    bus.ALUResultE = 32'h0000_1234;
    check_comb();
    step();
    check_eq("t1_RegWriteM", 64'(bus.RegWriteM), 64'h1);
    check_eq("t1_WA3M", 64'(bus.WA3M), 64'h5);
    check_eq("t1_ALUResultM", 64'(bus.ALUResultM), 64'h1234);

    // EQ fails with Z=0: no flag write, store suppressed.
    set_idle();
    bus.CondE = 4'h0; bus.FlagWriteE = 2'b11; bus.ALUFlags = 4'b0100;
    check_comb();
    check_eq("t2_CondExE", 64'(bus.CondExE), 64'h0);
    step();
    check_eq("t2_Flags", 64'(bus.Flags), 64'h0);
    set_idle();
    bus.CondE = 4'h0; bus.MemWriteE = 1'b1;
    check_comb();
    step();
    check_eq("t2_MemWriteM", 64'(bus.MemWriteM), 64'h0);
    set_flags(4'b0100);
    check_eq("t2_Flags_set", 64'(bus.Flags), 64'h4);
    set_idle();
    bus.CondE = 4'h0; bus.MemWriteE = 1'b1;
    check_comb();
    step();
    check_eq("t2_MemWriteM_eq", 64'(bus.MemWriteM), 64'h1);

    // Partial flag update: only N,Z written.
    set_flags(4'b1111);
    set_idle();
    bus.FlagWriteE = 2'b10; bus.ALUFlags = 4'b0000;
    step();
    check_eq("t3_partial", 64'(bus.Flags), 64'h3);

    // Full condition sweep.
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      bus.PCSrcE = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bus.CondE = 4'(c);
        check_comb();
        if (f == 4'b1001 && c == 4'hA) check_eq("GE_N1V1", 64'(bus.CondExE), 64'h1);
        if (f == 4'b1000 && c == 4'hD) check_eq("LE_Z0N1V0", 64'(bus.CondExE), 64'h1);
        if (f == 4'b0110 && c == 4'h8) check_eq("HI_C1Z1", 64'(bus.CondExE), 64'h0);
      end
    end

    // Stall holds *M and flags for two cycles of changing inputs.
    set_flags(4'b0000);
    set_idle();
    bus.RegWriteE = 1'b1; bus.ALUResultE = 32'hCAFE_0001; bus.WA3E = 4'd3;
    step();
    hold_flags = bus.Flags;
    hold_alu   = bus.ALUResultM;
    for (int k = 0; k < 2; k++) begin
      bus.StallM = 1'b1; bus.FlagWriteE = 2'b11; bus.CondE = 4'hE;
      bus.ALUFlags = 4'($urandom_range(15, 1));
      bus.ALUResultE = $urandom; bus.WA3E = 4'(k + 8);
      step();
      check_eq("stall_Flags", 64'(bus.Flags), 64'(hold_flags));
      check_eq("stall_ALUResultM", 64'(bus.ALUResultM), 64'(hold_alu));
      check_eq("stall_RegWriteM", 64'(bus.RegWriteM), 64'h1);
    end
    bus.FlushM = 1'b1; bus.StallM = 1'b1; bus.ALUFlags = 4'hF;
    step();
    check_eq("flushstall_RegWriteM", 64'(bus.RegWriteM), 64'h0);
    check_eq("flushstall_Flags", 64'(bus.Flags), 64'(hold_flags));

    // Branch with NE.
    set_flags(4'b0000);
    set_idle();
    bus.PCSrcE = 1'b1; bus.CondE = 4'h1;
    check_comb();
    check_eq("br_taken", 64'(bus.BranchTakenE), 64'h1);
    step();
    check_eq("br_PCSrcM", 64'(bus.PCSrcM), 64'h1);
    set_flags(4'b0100);
    set_idle();
    bus.PCSrcE = 1'b1; bus.CondE = 4'h1;
    check_comb();
    check_eq("br_not_taken", 64'(bus.BranchTakenE), 64'h0);
    step();
    check_eq("br_PCSrcM_0", 64'(bus.PCSrcM), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      check_comb();
      step();
    end

    // Mid-cycle asynchronous reset clears immediately.
    drive_random();
    bus.FlushM = 1'b0; bus.StallM = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    check_comb();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
